// File: rtl/bc_round_ctrl.sv
// bc_round_ctrl
//
// Round controller for Bulls-and-Cows. In setup mode it latches the secret
// answer; in play mode it scores each legal guess into strikes (right digit,
// right place) and balls (right digit, wrong place). It walks a thermometer
// try bar down one step per scored guess and ends the round in WIN or LOSE.
//
// Parameters:
//   DIGITS     number of BCD digits per answer/guess (2..8)
//   MAX_TRIES  guesses per round (1..16), also the try bar width
//
// Ports:
//   CLK           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   mode_setup    level, 1 = setup (answer entry), 0 = play
//   ans_in        candidate answer, digit i in bits [4i+3:4i]
//   ans_legal     ans_in is all-BCD with no repeated digit
//   guess_in      submitted guess, same packing as ans_in
//   guess_valid   one-cycle strobe, guess_in is ready to score
//   guess_legal   guess_in is all-BCD with no repeated digit
//   answer_q      latched secret answer
//   strikes       strike count of the last scored guess
//   balls         ball count of the last scored guess
//   result_valid  one-cycle strobe when strikes/balls update
//   entry_clr     one-cycle strobe telling the digit-entry block to clear
//   try_bar       thermometer of remaining tries, LSB-justified
//   win, lose     levels, high in WIN / LOSE
//   state         SETUP=0, PLAY=1, WIN=2, LOSE=3
module bc_round_ctrl #(
  parameter int DIGITS    = 4,
  parameter int MAX_TRIES = 8,
  localparam int AW = 4 * DIGITS,
  localparam int CW = $clog2(DIGITS + 1)
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 mode_setup,
  input  logic [AW-1:0]        ans_in,
  input  logic                 ans_legal,
  input  logic [AW-1:0]        guess_in,
  input  logic                 guess_valid,
  input  logic                 guess_legal,
  output logic [AW-1:0]        answer_q,
  output logic [CW-1:0]        strikes,
  output logic [CW-1:0]        balls,
  output logic                 result_valid,
  output logic                 entry_clr,
  output logic [MAX_TRIES-1:0] try_bar,
  output logic                 win,
  output logic                 lose,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    ST_SETUP = 2'd0,
    ST_PLAY  = 2'd1,
    ST_WIN   = 2'd2,
    ST_LOSE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        answer_d;
  logic [AW-1:0]        guess_q, guess_d;
  logic                 legal_q, legal_d;
  logic                 pend_q, pend_d;
  logic [CW-1:0]        strikes_q, strikes_d;
  logic [CW-1:0]        balls_q, balls_d;
  logic                 result_valid_q, result_valid_d;
  logic                 entry_clr_q, entry_clr_d;
  logic [MAX_TRIES-1:0] try_bar_q, try_bar_d;

  logic [CW-1:0]        strike_cnt;
  logic [CW-1:0]        ball_cnt;
  logic                 ball_hit;
  logic [MAX_TRIES-1:0] try_shift;

  // Score the registered guess against the latched answer. A position is a
  // ball when its digit appears anywhere else in the answer.
  always_comb begin
    strike_cnt = '0;
    ball_cnt   = '0;
    ball_hit   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      ball_hit = 1'b0;
      if (guess_q[4*i +: 4] == answer_q[4*i +: 4]) begin
        strike_cnt = strike_cnt + CW'(1);
      end
      for (int j = 0; j < DIGITS; j++) begin
        if ((j != i) && (guess_q[4*i +: 4] == answer_q[4*j +: 4])) begin
          ball_hit = 1'b1;
        end
      end
      if (ball_hit) begin
        ball_cnt = ball_cnt + CW'(1);
      end
    end
  end

  assign try_shift = try_bar_q >> 1;

  // Next-state logic. mode_setup overrides everything, including a guess
  // already in flight. In PLAY, pend_q marks the second pipeline stage;
  // while it is set a new strobe is dropped.
  always_comb begin
    state_d        = state_q;
    answer_d       = answer_q;
    guess_d        = guess_q;
    legal_d        = legal_q;
    pend_d         = 1'b0;
    strikes_d      = strikes_q;
    balls_d        = balls_q;
    try_bar_d      = try_bar_q;
    result_valid_d = 1'b0;
    entry_clr_d    = 1'b0;

    if (mode_setup) begin
      state_d   = ST_SETUP;
      try_bar_d = '1;
      strikes_d = '0;
      balls_d   = '0;
      if (ans_legal) begin
        answer_d = ans_in;
      end
    end else begin
      case (state_q)
        ST_SETUP: begin
          state_d     = ST_PLAY;
          entry_clr_d = 1'b1;
        end
        ST_PLAY: begin
          if (pend_q) begin
            entry_clr_d = 1'b1;
            if (legal_q) begin
              result_valid_d = 1'b1;
              strikes_d      = strike_cnt;
              balls_d        = ball_cnt;
              try_bar_d      = try_shift;
              // A full match wins even when it used up the last try.
              if (strike_cnt == CW'(DIGITS)) begin
                state_d = ST_WIN;
              end else if (try_shift == '0) begin
                state_d = ST_LOSE;
              end
            end
          end else if (guess_valid) begin
            pend_d  = 1'b1;
            guess_d = guess_in;
            legal_d = guess_legal;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State and pipeline registers.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_SETUP;
      answer_q       <= '0;
      guess_q        <= '0;
      legal_q        <= 1'b0;
      pend_q         <= 1'b0;
      strikes_q      <= '0;
      balls_q        <= '0;
      result_valid_q <= 1'b0;
      entry_clr_q    <= 1'b0;
      try_bar_q      <= '1;
    end else begin
      state_q        <= state_d;
      answer_q       <= answer_d;
      guess_q        <= guess_d;
      legal_q        <= legal_d;
      pend_q         <= pend_d;
      strikes_q      <= strikes_d;
      balls_q        <= balls_d;
      result_valid_q <= result_valid_d;
      entry_clr_q    <= entry_clr_d;
      try_bar_q      <= try_bar_d;
    end
  end

  assign strikes      = strikes_q;
  assign balls        = balls_q;
  assign result_valid = result_valid_q;
  assign entry_clr    = entry_clr_q;
  assign try_bar      = try_bar_q;
  assign win          = (state_q == ST_WIN);
  assign lose         = (state_q == ST_LOSE);
  assign state        = state_q;

endmodule

// File: tb/tb_bc_round_ctrl.sv
// Testbench for bc_round_ctrl. Instance A uses the default 4-digit, 8-try
// configuration; instance B uses 6 digits and 3 tries. Expected results are
// queued when a guess is issued and popped by per-instance monitors whenever
// the DUT strobes result_valid or entry_clr.
module tb_bc_round_ctrl;

  typedef struct {
    int s;
    int b;
    int bar;
    int st;
    int w;
    int l;
  } exp_t;

  logic clk = 1'b0;

  logic        rst_n, mode_setup, ans_legal, guess_valid, guess_legal;
  logic [15:0] ans_in, guess_in, answer_q;
  logic [2:0]  strikes, balls;
  logic        result_valid, entry_clr, win, lose;
  logic [7:0]  try_bar;
  logic [1:0]  state;

  logic        rst_n_b, mode_setup_b, ans_legal_b, guess_valid_b, guess_legal_b;
  logic [23:0] ans_in_b, guess_in_b, answer_q_b;
  logic [2:0]  strikes_b, balls_b;
  logic        result_valid_b, entry_clr_b, win_b, lose_b;
  logic [2:0]  try_bar_b;
  logic [1:0]  state_b;

  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  int   ea = 0;
  int   eb = 0;

  // Free-running 100 MHz clock shared by both instances.
  always #5 clk = ~clk;

  bc_round_ctrl dut_a (
    .CLK(clk), .rst_n(rst_n), .mode_setup(mode_setup), .ans_in(ans_in),
    .ans_legal(ans_legal), .guess_in(guess_in), .guess_valid(guess_valid),
    .guess_legal(guess_legal), .answer_q(answer_q), .strikes(strikes),
    .balls(balls), .result_valid(result_valid), .entry_clr(entry_clr),
    .try_bar(try_bar), .win(win), .lose(lose), .state(state)
  );

  bc_round_ctrl #(.DIGITS(6), .MAX_TRIES(3)) dut_b (
    .CLK(clk), .rst_n(rst_n_b), .mode_setup(mode_setup_b), .ans_in(ans_in_b),
    .ans_legal(ans_legal_b), .guess_in(guess_in_b), .guess_valid(guess_valid_b),
    .guess_legal(guess_legal_b), .answer_q(answer_q_b), .strikes(strikes_b),
    .balls(balls_b), .result_valid(result_valid_b), .entry_clr(entry_clr_b),
    .try_bar(try_bar_b), .win(win_b), .lose(lose_b), .state(state_b)
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor for instance A: pops the scoreboard on each result strobe and
  // consumes one expected entry_clr pulse per strobe.
  always @(negedge clk) begin
    exp_t e;
    if (result_valid === 1'b1) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL A unexpected result_valid: got 1, expected 0");
      end else begin
        e = qa.pop_front();
        checkOutput("A strikes", 32'(strikes), e.s);
        checkOutput("A balls",   32'(balls),   e.b);
        checkOutput("A try_bar", 32'(try_bar), e.bar);
        checkOutput("A state",   32'(state),   e.st);
        checkOutput("A win",     32'(win),     e.w);
        checkOutput("A lose",    32'(lose),    e.l);
      end
    end
    if (entry_clr === 1'b1) begin
      checks++;
      if (ea == 0) begin
        errors++;
        $display("[TB] FAIL A unexpected entry_clr: got 1, expected 0");
      end else begin
        ea--;
      end
    end
  end

  // Monitor for instance B, same scheme as A.
  always @(negedge clk) begin
    exp_t e;
    if (result_valid_b === 1'b1) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL B unexpected result_valid: got 1, expected 0");
      end else begin
        e = qb.pop_front();
        checkOutput("B strikes", 32'(strikes_b), e.s);
        checkOutput("B balls",   32'(balls_b),   e.b);
        checkOutput("B try_bar", 32'(try_bar_b), e.bar);
        checkOutput("B state",   32'(state_b),   e.st);
        checkOutput("B win",     32'(win_b),     e.w);
        checkOutput("B lose",    32'(lose_b),    e.l);
      end
    end
    if (entry_clr_b === 1'b1) begin
      checks++;
      if (eb == 0) begin
        errors++;
        $display("[TB] FAIL B unexpected entry_clr: got 1, expected 0");
      end else begin
        eb--;
      end
    end
  end

  // Enter setup on A, present an answer, then drop mode_setup into PLAY.
  task automatic doSetup(input logic [15:0] ans, input logic legal);
    mode_setup = 1'b1;
    ans_in     = ans;
    ans_legal  = legal;
    tick();
    checkOutput("A setup state",   32'(state),   0);
    checkOutput("A setup try_bar", 32'(try_bar), 32'hFF);
    checkOutput("A setup win",     32'(win),     0);
    checkOutput("A setup lose",    32'(lose),    0);
    checkOutput("A setup strikes", 32'(strikes), 0);
    checkOutput("A setup balls",   32'(balls),   0);
    tick();
    mode_setup = 1'b0;
    ea++;
    tick();
    checkOutput("A play state", 32'(state), 1);
  endtask

  // Issue one guess on A. scored pushes an expected result, clr expects an
  // entry_clr pulse; three cycles keep strobes spaced apart.
  task automatic applyStimulus(input logic [15:0] g, input logic legal,
                               input bit scored, input bit clr,
                               input int s, input int b, input int bar,
                               input int st, input int w, input int l);
    exp_t e;
    if (scored) begin
      e = '{s: s, b: b, bar: bar, st: st, w: w, l: l};
      qa.push_back(e);
    end
    if (clr) ea++;
    guess_in    = g;
    guess_legal = legal;
    guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    tick();
    tick();
  endtask

  // Main directed sequence.
  initial begin
    exp_t e;
    rst_n = 1'b0;  mode_setup = 1'b1;  ans_in = '0;  ans_legal = 1'b0;
    guess_in = '0;  guess_valid = 1'b0;  guess_legal = 1'b0;
    rst_n_b = 1'b0;  mode_setup_b = 1'b1;  ans_in_b = '0;  ans_legal_b = 1'b0;
    guess_in_b = '0;  guess_valid_b = 1'b0;  guess_legal_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rst_n_b = 1'b1;
    tick();
    checkOutput("A reset state",        32'(state),        0);
    checkOutput("A reset answer_q",     32'(answer_q),     0);
    checkOutput("A reset strikes",      32'(strikes),      0);
    checkOutput("A reset balls",        32'(balls),        0);
    checkOutput("A reset result_valid", 32'(result_valid), 0);
    checkOutput("A reset entry_clr",    32'(entry_clr),    0);
    checkOutput("A reset try_bar",      32'(try_bar),      32'hFF);
    checkOutput("A reset win",          32'(win),          0);
    checkOutput("A reset lose",         32'(lose),         0);

    // Exact guess wins on the first try.
    doSetup(16'h1234, 1'b1);
    checkOutput("A answer latched", 32'(answer_q), 32'h1234);
    applyStimulus(16'h1234, 1, 1, 1, 4, 0, 32'h7F, 2, 1, 0);
    // Guesses in WIN are ignored and scores stay frozen.
    applyStimulus(16'h5678, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("A win frozen state",   32'(state),   2);
    checkOutput("A win frozen strikes", 32'(strikes), 4);

    // Illegal answer during setup keeps the previous answer.
    doSetup(16'h5555, 1'b0);
    checkOutput("A answer retained", 32'(answer_q), 32'h1234);
    applyStimulus(16'h1243, 1, 1, 1, 2, 2, 32'h7F, 1, 0, 0);
    // Illegal guess: entry_clr only, no try consumed.
    applyStimulus(16'h1134, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("A illegal entry_clr seen", 32'(ea), 0);
    checkOutput("A illegal try_bar",        32'(try_bar), 32'h7F);
    applyStimulus(16'h4321, 1, 1, 1, 0, 4, 32'h3F, 1, 0, 0);
    applyStimulus(16'h2135, 1, 1, 1, 1, 2, 32'h1F, 1, 0, 0);

    // Back-to-back strobes: the second (a winning guess) is dropped.
    e = '{s: 0, b: 0, bar: 32'h0F, st: 1, w: 0, l: 0};
    qa.push_back(e);
    ea++;
    guess_in = 16'h5678;  guess_legal = 1'b1;  guess_valid = 1'b1;
    tick();
    guess_in = 16'h1234;
    tick();
    guess_valid = 1'b0;
    tick();
    tick();
    checkOutput("A dropped guess state", 32'(state), 1);

    // mode_setup during an in-flight guess discards it.
    guess_in = 16'h1234;  guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    mode_setup = 1'b1;  ans_in = 16'h1234;  ans_legal = 1'b1;
    tick();
    checkOutput("A inflight result_valid", 32'(result_valid), 0);
    checkOutput("A inflight state",        32'(state),        0);
    checkOutput("A inflight try_bar",      32'(try_bar),      32'hFF);
    doSetup(16'h1234, 1'b1);

    // Exhaustion: eight misses walk the bar down to LOSE.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(16'h5678, 1, 1, 1, 0, 0, 32'(8'hFF >> (i + 1)),
                    (i == 7) ? 3 : 1, 0, (i == 7) ? 1 : 0);
    end
    applyStimulus(16'h5678, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("A lose held",     32'(lose),    1);
    checkOutput("A lose try_bar",  32'(try_bar), 0);

    // Re-enter setup from LOSE, then win on the very last try.
    doSetup(16'h1234, 1'b1);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(16'h5678, 1, 1, 1, 0, 0, 32'(8'hFF >> (i + 1)), 1, 0, 0);
    end
    applyStimulus(16'h1234, 1, 1, 1, 4, 0, 0, 2, 1, 0);

    // Instance B: six digits, three tries, all-balls guess.
    ans_in_b = 24'h012345;  ans_legal_b = 1'b1;
    tick();
    mode_setup_b = 1'b0;
    eb++;
    tick();
    checkOutput("B play state", 32'(state_b),    1);
    checkOutput("B answer",     32'(answer_q_b), 32'h012345);
    e = '{s: 0, b: 6, bar: 3, st: 1, w: 0, l: 0};
    qb.push_back(e);
    eb++;
    guess_in_b = 24'h543210;  guess_legal_b = 1'b1;  guess_valid_b = 1'b1;
    tick();
    guess_valid_b = 1'b0;
    tick();
    tick();

    // Reset one cycle after the strobe: the in-flight guess is lost.
    guess_in_b = 24'h012345;  guess_valid_b = 1'b1;
    tick();
    guess_valid_b = 1'b0;
    rst_n_b = 1'b0;
    mode_setup_b = 1'b1;
    #1;
    checkOutput("B rst state",        32'(state_b),        0);
    checkOutput("B rst answer_q",     32'(answer_q_b),     0);
    checkOutput("B rst strikes",      32'(strikes_b),      0);
    checkOutput("B rst balls",        32'(balls_b),        0);
    checkOutput("B rst result_valid", 32'(result_valid_b), 0);
    checkOutput("B rst entry_clr",    32'(entry_clr_b),    0);
    checkOutput("B rst try_bar",      32'(try_bar_b),      7);
    checkOutput("B rst win",          32'(win_b),          0);
    checkOutput("B rst lose",         32'(lose_b),         0);
    tick();
    checkOutput("B rst held result_valid", 32'(result_valid_b), 0);
    rst_n_b = 1'b1;
    repeat (3) tick();

    checkOutput("A results outstanding",   32'(qa.size()), 0);
    checkOutput("B results outstanding",   32'(qb.size()), 0);
    checkOutput("A entry_clr outstanding", 32'(ea),        0);
    checkOutput("B entry_clr outstanding", 32'(eb),        0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/bc_round_ctrl.md
# bc_round_ctrl

Parametrised round controller for the Bulls-and-Cows game. It latches a secret answer in setup mode, accepts guesses, and scores each one into strikes (right digit, right place) and balls (right digit, wrong place). It tracks the remaining tries on a thermometer LED bar and ends the round in WIN or LOSE. It sits between the digit-entry/answer-setting logic and the LED, LCD, piezo and motor feedback blocks, and generalises the fixed 4-digit, 8-try round handling.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits per answer/guess (2..8)
- MAX_TRIES, 8, guesses allowed per round (1..16); also the width of the try bar

Ports:
- CLK  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- mode_setup  in  1  level; 1 = setup mode (answer entry), 0 = play mode
- ans_in  in  4*DIGITS  candidate answer; digit i in bits [4i+3:4i], digit 0 rightmost
- ans_legal  in  1  ans_in is all-BCD with no repeated digit
- guess_in  in  4*DIGITS  submitted guess, same packing as ans_in
- guess_valid  in  1  one-cycle strobe: guess_in is ready to score
- guess_legal  in  1  guess_in is all-BCD with no repeated digit; sampled with guess_valid
- answer_q  out  4*DIGITS  latched secret answer
- strikes  out  $clog2(DIGITS+1)  strike count of the last scored guess
- balls  out  $clog2(DIGITS+1)  ball count of the last scored guess
- result_valid  out  1  one-cycle strobe when strikes/balls update
- entry_clr  out  1  one-cycle strobe that tells the digit-entry block to clear
- try_bar  out  MAX_TRIES  thermometer of remaining tries, LSB-justified
- win  out  1  level; high in WIN
- lose  out  1  level; high in LOSE
- state  out  2  SETUP=0, PLAY=1, WIN=2, LOSE=3

## Operation
- Reset values: state SETUP, answer_q 0, strikes 0, balls 0, result_valid 0, entry_clr 0, try_bar all ones, win 0, lose 0.

SETUP:
- While mode_setup=1 and ans_legal=1, answer_q <= ans_in every cycle.
- try_bar is held at all ones.
- On mode_setup falling (1 -> 0) the block goes to PLAY.
  - If ans_legal was 0 on the last setup cycle, answer_q keeps its previous value.
- entry_clr pulses on that transition.

PLAY:
- A guess is scored only when guess_valid=1 and guess_legal=1.
  - Illegal guesses are ignored: no try is consumed, no result_valid.
  - entry_clr still pulses for an illegal guess.
- Scoring, for each guess position i:
  - strike if g[i]==a[i];
  - ball if g[i]==a[j] for some j≠i.
  - Counts are exact sums; both fit in $clog2(DIGITS+1) bits.
- Per accepted guess: try_bar <= try_bar >> 1, entry_clr pulses.
- After scoring:
  - strikes==DIGITS -> WIN. This takes priority even if it was the last try.
  - else if try_bar after the shift == 0 -> LOSE.
  - else stay in PLAY.

WIN / LOSE:
- Terminal states. guess_valid is ignored; strikes, balls and try_bar are frozen.
- win/lose are asserted as levels.

From any state:
- mode_setup=1 -> SETUP on the next edge.
  - try_bar is reloaded to all ones, win/lose are cleared, strikes/balls are cleared to 0.
  - answer_q is retained until a legal ans_in is latched.

## Timing
- Scoring is a 2-stage pipeline.
  - Edge 1 registers the guess.
  - Edge 2 updates strikes, balls, try_bar and state, and asserts result_valid and entry_clr for one cycle.
- Latency from the guess_valid edge to result_valid is 2 cycles.
- A guess_valid arriving while a score is in flight (the cycle after a previous guess_valid) is dropped.
  - The guess source must space strobes by ≥2 cycles.
- mode_setup=1 in the same cycle as guess_valid: setup wins and the guess is discarded.
  - This includes a guess already in flight.
- The SETUP -> PLAY transition takes effect on the first edge where mode_setup=0.
  - guess_valid on that same edge is ignored.
- The transition to WIN or LOSE is on the same edge as result_valid.
- Asynchronous reset mid-score: everything returns to reset values immediately and the in-flight guess is lost.

## Test plan
- Setup then an exact guess.
  - Stimulus: DIGITS=4, MAX_TRIES=8; setup ans_in=0x1234 legal, drop mode_setup; guess 0x1234.
  - Required: 2 cycles later result_valid=1, strikes=4, balls=0, win=1, state=2, try_bar=0x7F.
- Mixed score.
  - Stimulus: answer 0x1234, guess 0x1243.
  - Required: strikes=2, balls=2, state stays PLAY, try_bar 0xFF -> 0x7F.
- Exhaustion.
  - Stimulus: answer 0x1234; 8 legal guesses of 0x5678.
  - Required: each gives 0/0; try_bar walks 0xFF -> 0x00; lose=1 on the 8th result.
  - A 9th guess_valid produces no result_valid.
- Last-try win.
  - Stimulus: 7 wrong guesses, then 0x1234.
  - Required: win=1, lose=0, try_bar=0x00.
- Illegal guesses and re-entering setup.
  - Stimulus: guess_valid with guess_legal=0.
  - Required: entry_clr pulses, result_valid stays 0, try_bar unchanged.
  - Stimulus: raise mode_setup from LOSE.
  - Required: state=0, try_bar=0xFF, win=lose=0.
- Parameter sweep and mid-score reset.
  - Stimulus: DIGITS=6, MAX_TRIES=3; answer 0x012345, guess 0x543210.
  - Required: strikes=0, balls=6.
  - Stimulus: assert rst_n=0 one cycle after guess_valid.
  - Required: no result_valid; all outputs return to reset values.
